// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, functs, ALU/PC codes,
// sequencer states and instruction classes.
package cpu_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnMul = 6'b011000;
    localparam logic [5:0] FnDiv = 6'b011010;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluMul = 4'b0010;
    localparam logic [3:0] AluDiv = 4'b0011;
    localparam logic [3:0] AluAnd = 4'b0100;
    localparam logic [3:0] AluOr  = 4'b0101;

    localparam logic [1:0] PcInc    = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;
    localparam logic [1:0] PcHold   = 2'b11;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StMdWait, StMem, StWriteback
    } state_e;

    typedef enum logic [2:0] {
        ClsRtype, ClsMulDiv, ClsAddi, ClsLw, ClsSw, ClsBeq, ClsJ, ClsIllegal
    } instr_cls_e;

    // Unknown functs fall back to ADD; also used by the single-cycle control unit.
    function automatic logic [3:0] alu_from_funct(input logic [5:0] funct);
        case (funct)
            FnAdd:   return AluAdd;
            FnSub:   return AluSub;
            FnMul:   return AluMul;
            FnDiv:   return AluDiv;
            FnAnd:   return AluAnd;
            FnOr:    return AluOr;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/funct decode into an instruction class and ALU operation.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output instr_cls_e cls_o,
    output logic [3:0] alu_sel_o
);

    always_comb begin
        cls_o     = ClsIllegal;
        alu_sel_o = AluAdd;
        case (opcode_i)
            OpRtype: begin
                alu_sel_o = alu_from_funct(funct_i);
                cls_o     = (funct_i == FnMul || funct_i == FnDiv) ? ClsMulDiv : ClsRtype;
            end
            OpAddi: cls_o = ClsAddi;
            OpLw:   cls_o = ClsLw;
            OpSw:   cls_o = ClsSw;
            OpBeq: begin
                cls_o     = ClsBeq;
                alu_sel_o = AluSub;
            end
            OpJ:     cls_o = ClsJ;
            default: cls_o = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle main controller: FETCH/DECODE/EXECUTE/MD_WAIT/MEM/WRITEBACK sequencing with
// combinational strobe decode from state and the current instruction.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic [3:0] ALU_Selection,
    output logic [1:0] PC_Select,
    output logic       busy,
    output logic       instr_done,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    instr_cls_e cls;
    logic [3:0] alu_sel;

    instr_decode u_decode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .cls_o    (cls),
        .alu_sel_o(alu_sel)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrc        = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemToReg      = 1'b0;
        ALU_Selection = AluAdd;
        PC_Select     = PcHold;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            StIdle: if (en) state_d = StFetch;
            StFetch: begin
                IRWrite = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                if (cls == ClsIllegal) begin
                    illegal    = 1'b1;
                    PCWrite    = 1'b1;
                    PC_Select  = PcInc;
                    instr_done = 1'b1;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                case (cls)
                    ClsRtype: begin
                        ALU_Selection = alu_sel;
                        state_d       = StWriteback;
                    end
                    ClsMulDiv: begin
                        ALU_Selection = alu_sel;
                        cnt_d         = 4'(MULDIV_CYCLES - 1);
                        state_d       = StMdWait;
                    end
                    ClsAddi: begin
                        ALUSrc  = 1'b1;
                        state_d = StWriteback;
                    end
                    ClsLw, ClsSw: begin
                        ALUSrc  = 1'b1;
                        state_d = StMem;
                    end
                    ClsBeq: begin
                        ALU_Selection = AluSub;
                        PCWrite       = 1'b1;
                        PC_Select     = zero ? PcBranch : PcInc;
                        instr_done    = 1'b1;
                    end
                    ClsJ: begin
                        PCWrite    = 1'b1;
                        PC_Select  = PcJump;
                        instr_done = 1'b1;
                    end
                    default: state_d = StIdle;
                endcase
            end
            StMdWait: begin
                ALU_Selection = alu_sel;
                if (cnt_q == 4'd0) state_d = StWriteback;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StMem: begin
                MemRead  = (cls == ClsLw);
                MemWrite = (cls != ClsLw);
                if (mem_ready) begin
                    if (cls == ClsLw) begin
                        state_d = StWriteback;
                    end else begin
                        PCWrite    = 1'b1;
                        PC_Select  = PcInc;
                        instr_done = 1'b1;
                    end
                end
            end
            StWriteback: begin
                // Keep the instruction's ALU op and operand source stable through the write.
                ALU_Selection = alu_sel;
                ALUSrc        = (cls == ClsAddi || cls == ClsLw);
                MemToReg      = (cls == ClsLw);
                RegWrite      = 1'b1;
                PCWrite       = 1'b1;
                PC_Select     = PcInc;
                instr_done    = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // en is only consulted at completion, so a mid-instruction drop never aborts.
        if (instr_done) state_d = en ? StFetch : StIdle;
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a per-instruction timeline model produces the expected strobes for
// every cycle; one compare process checks the selected DUT on each falling edge.
module tb_cpu_sequencer;

    typedef struct packed {
        logic       irw, pcw, rw, src, mr, mw, m2r;
        logic [3:0] alu;
        logic [1:0] pcs;
        logic       busy, done, ill;
    } outs_t;

    typedef struct {
        outs_t      o;
        logic       rst;
        logic       en;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        logic       sel;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en1 = 1'b0, en2 = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;

    logic       irw1, pcw1, rw1, src1, mr1, mw1, m2r1, busy1, done1, ill1;
    logic [3:0] alu1;
    logic [1:0] pcs1;
    logic       irw2, pcw2, rw2, src2, mr2, mw2, m2r2, busy2, done2, ill2;
    logic [3:0] alu2;
    logic [1:0] pcs2;
    outs_t      act1, act2, act_c, exp_o;

    assign act1 = {irw1, pcw1, rw1, src1, mr1, mw1, m2r1, alu1, pcs1, busy1, done1, ill1};
    assign act2 = {irw2, pcw2, rw2, src2, mr2, mw2, m2r2, alu2, pcs2, busy2, done2, ill2};

    always #5 clk = ~clk;

    cpu_sequencer #(.MULDIV_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .IRWrite(irw1), .PCWrite(pcw1), .RegWrite(rw1), .ALUSrc(src1),
        .MemRead(mr1), .MemWrite(mw1), .MemToReg(m2r1), .ALU_Selection(alu1),
        .PC_Select(pcs1), .busy(busy1), .instr_done(done1), .illegal(ill1)
    );

    cpu_sequencer #(.MULDIV_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .IRWrite(irw2), .PCWrite(pcw2), .RegWrite(rw2), .ALUSrc(src2),
        .MemRead(mr2), .MemWrite(mw2), .MemToReg(m2r2), .ALU_Selection(alu2),
        .PC_Select(pcs2), .busy(busy2), .instr_done(done2), .illegal(ill2)
    );

    int         n_tests = 0;
    int         n_fail = 0;
    int         lat_run = 0;
    int         last_lat = -1;
    int         plan_len = 0;
    logic       exp_valid = 1'b0;
    logic       cmp_sel = 1'b0;
    string      cur_name = "init";
    step_t      plan[$];
    logic       p_sel = 1'b0;
    logic [5:0] p_op = 6'd0, p_fn = 6'd0;

    always @(negedge clk) begin
        if (exp_valid) begin
            act_c = cmp_sel ? act2 : act1;
            n_tests++;
            if (act_c !== exp_o) begin
                n_fail++;
                $display("FAIL %s @%0t: dut=%b model=%b (irw pcw rw src mr mw m2r alu pcs busy done ill)",
                         cur_name, $time, act_c, exp_o);
            end
            if (act_c.irw) lat_run = 1;
            else if (act_c.busy) lat_run++;
            if (act_c.done) last_lat = lat_run;
        end
    end

    function automatic logic [3:0] model_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0001;
            6'b011000: return 4'b0010;
            6'b011010: return 4'b0011;
            6'b100100: return 4'b0100;
            6'b100101: return 4'b0101;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic outs_t base();
        outs_t r;
        r      = '0;
        r.pcs  = 2'b11;
        r.busy = 1'b1;
        return r;
    endfunction

    task automatic push(input outs_t o, input logic rdy, input logic z, input logic en_v,
                        input logic rst_v);
        step_t s;
        s.o = o; s.rst = rst_v; s.en = en_v; s.op = p_op; s.fn = p_fn;
        s.z = z; s.rdy = rdy; s.sel = p_sel;
        plan.push_back(s);
    endtask

    task automatic plan_idle(input logic en_v, input logic rst_v);
        outs_t o;
        o     = '0;
        o.pcs = 2'b11;
        push(o, 1'b1, 1'b0, en_v, rst_v);
    endtask

    // Timeline of one instruction from FETCH to its final cycle.
    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int w, input logic en_end, input int md);
        outs_t      o;
        logic [3:0] a;
        bit         is_md;
        p_op  = op;
        p_fn  = fn;
        a     = model_alu(fn);
        is_md = (op == 6'b000000) && (fn == 6'b011000 || fn == 6'b011010);
        o = base(); o.irw = 1'b1; push(o, 1'b1, 1'b0, 1'b1, 1'b1);
        o = base();
        case (op)
            6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010:
                push(o, 1'b1, 1'b0, 1'b1, 1'b1);
            default: begin
                o.ill = 1'b1; o.pcw = 1'b1; o.pcs = 2'b00; o.done = 1'b1;
                push(o, 1'b1, 1'b0, en_end, 1'b1);
                return;
            end
        endcase
        case (op)
            6'b000000: begin
                o = base(); o.alu = a; push(o, 1'b1, 1'b0, 1'b1, 1'b1);
                if (is_md) for (int i = 0; i < md; i++) push(o, 1'b1, 1'b0, 1'b1, 1'b1);
                o.rw = 1'b1; o.pcw = 1'b1; o.pcs = 2'b00; o.done = 1'b1;
                push(o, 1'b1, 1'b0, en_end, 1'b1);
            end
            6'b001000: begin
                o = base(); o.src = 1'b1; push(o, 1'b1, 1'b0, 1'b1, 1'b1);
                o.rw = 1'b1; o.pcw = 1'b1; o.pcs = 2'b00; o.done = 1'b1;
                push(o, 1'b1, 1'b0, en_end, 1'b1);
            end
            6'b100011: begin
                o = base(); o.src = 1'b1; push(o, 1'b1, 1'b0, 1'b1, 1'b1);
                o = base(); o.mr = 1'b1;
                for (int i = 0; i < w; i++) push(o, 1'b0, 1'b0, 1'b1, 1'b1);
                push(o, 1'b1, 1'b0, 1'b1, 1'b1);
                o = base(); o.src = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.pcw = 1'b1;
                o.pcs = 2'b00; o.done = 1'b1;
                push(o, 1'b1, 1'b0, en_end, 1'b1);
            end
            6'b101011: begin
                o = base(); o.src = 1'b1; push(o, 1'b1, 1'b0, 1'b1, 1'b1);
                o = base(); o.mw = 1'b1;
                for (int i = 0; i < w; i++) push(o, 1'b0, 1'b0, 1'b1, 1'b1);
                o.pcw = 1'b1; o.pcs = 2'b00; o.done = 1'b1;
                push(o, 1'b1, 1'b0, en_end, 1'b1);
            end
            6'b000100: begin
                o = base(); o.alu = 4'b0001; o.pcw = 1'b1; o.done = 1'b1;
                o.pcs = z ? 2'b01 : 2'b00;
                push(o, 1'b1, z, en_end, 1'b1);
            end
            default: begin
                o = base(); o.pcw = 1'b1; o.pcs = 2'b10; o.done = 1'b1;
                push(o, 1'b1, 1'b0, en_end, 1'b1);
            end
        endcase
    endtask

    task automatic run_plan();
        step_t s;
        plan_len = plan.size();
        last_lat = -1;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(posedge clk);
            #1;
            rst_n     = s.rst;
            en1       = s.sel ? 1'b0 : s.en;
            en2       = s.sel ? s.en : 1'b0;
            opcode    = s.op;
            funct     = s.fn;
            zero      = s.z;
            mem_ready = s.rdy;
            cmp_sel   = s.sel;
            exp_o     = s.o;
            exp_valid = 1'b1;
        end
    endtask

    // Pins both the model's timeline length and the DUT's FETCH-to-done count to a literal.
    task automatic check_lat(input string nm, input int want);
        @(negedge clk);
        #1;
        n_tests++;
        if (plan_len != want) begin
            n_fail++;
            $display("FAIL %s model latency: got %0d want %0d", nm, plan_len, want);
        end
        n_tests++;
        if (last_lat != want) begin
            n_fail++;
            $display("FAIL %s dut latency: got %0d want %0d", nm, last_lat, want);
        end
    endtask

    task automatic instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int w, input logic en_end, input int md,
                         input int want_lat);
        cur_name = nm;
        plan_instr(op, fn, z, w, en_end, md);
        run_plan();
        check_lat(nm, want_lat);
    endtask

    initial begin
        cur_name = "reset";
        repeat (3) plan_idle(1'b1, 1'b0);
        plan_idle(1'b1, 1'b1);
        run_plan();

        instr("add",     6'b000000, 6'b100000, 1'b0, 0, 1'b1, 4, 4);
        instr("sub",     6'b000000, 6'b100010, 1'b0, 0, 1'b1, 4, 4);
        instr("and",     6'b000000, 6'b100100, 1'b0, 0, 1'b1, 4, 4);
        instr("or",      6'b000000, 6'b100101, 1'b0, 0, 1'b1, 4, 4);
        instr("rfunct0", 6'b000000, 6'b000000, 1'b0, 0, 1'b1, 4, 4);
        instr("mul",     6'b000000, 6'b011000, 1'b0, 0, 1'b1, 4, 8);
        instr("div",     6'b000000, 6'b011010, 1'b0, 0, 1'b1, 4, 8);
        instr("addi",    6'b001000, 6'b010101, 1'b0, 0, 1'b1, 4, 4);
        instr("lw_w3",   6'b100011, 6'b000000, 1'b0, 3, 1'b1, 4, 8);
        instr("lw_w0",   6'b100011, 6'b000000, 1'b0, 0, 1'b1, 4, 5);
        instr("sw_w0",   6'b101011, 6'b000000, 1'b0, 0, 1'b1, 4, 4);
        instr("sw_w2",   6'b101011, 6'b000000, 1'b0, 2, 1'b1, 4, 6);
        instr("beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 1'b1, 4, 3);
        instr("beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 1'b1, 4, 3);
        instr("j",       6'b000010, 6'b000000, 1'b0, 0, 1'b1, 4, 3);
        instr("illegal", 6'b111111, 6'b000000, 1'b0, 0, 1'b0, 4, 2);

        cur_name = "idle_en0";
        plan_idle(1'b0, 1'b1);
        plan_idle(1'b0, 1'b1);
        plan_idle(1'b1, 1'b1);
        run_plan();

        cur_name = "lw_abort";
        plan_instr(6'b100011, 6'b000000, 1'b0, 5, 1'b1, 4);
        while (plan.size() > 5) void'(plan.pop_back());
        plan_idle(1'b1, 1'b0);
        plan_idle(1'b1, 1'b1);
        run_plan();

        cur_name = "mul_abort";
        plan_instr(6'b000000, 6'b011000, 1'b0, 0, 1'b1, 4);
        while (plan.size() > 5) void'(plan.pop_back());
        plan_idle(1'b1, 1'b0);
        plan_idle(1'b1, 1'b1);
        run_plan();

        instr("add_last", 6'b000000, 6'b100000, 1'b0, 0, 1'b0, 4, 4);
        cur_name = "idle_end";
        plan_idle(1'b0, 1'b1);
        plan_idle(1'b0, 1'b1);
        run_plan();

        p_sel    = 1'b1;
        cur_name = "md1_start";
        plan_idle(1'b1, 1'b1);
        run_plan();
        instr("mul_md1", 6'b000000, 6'b011000, 1'b0, 0, 1'b0, 1, 5);
        cur_name = "md1_idle";
        plan_idle(1'b0, 1'b1);
        run_plan();

        @(negedge clk);
        #1;
        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
